// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the instruction cache.
// Provides the default-geometry address breakdown, the frame record and the
// cache controller state encoding.
package cpu_types_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    // Fetch address split for the default geometry
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // One direct-mapped instruction frame
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   imemREN, imemaddr    datapath fetch request and byte address
//   ihit, imemload       hit flag and frame data at the current index
//   iREN, iaddr          fill request and frozen fill word address
//   iwait, iload         memory busy flag and fill data
//   hit_count            cycles with ihit high (wrapping)
//   miss_count           misses issued (wrapping)
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned ITAG_W = 32 - IDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IDX_W-1:0]  idx;
        logic [1:0]        bytoff;
    } addr_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } frame_t;

    frame_t                  frames [SETS];
    icache_state_t           state, nextState;
    logic [ITAG_W+IDX_W-1:0] missAddr;
    addr_t                   req;
    logic [IDX_W-1:0]        fillIdx;
    logic [ITAG_W-1:0]       fillTag;
    logic                    lookupHit, missStart, fillDone;
    logic [1:0]              unusedBytOff;

    assign req          = addr_t'(imemaddr);
    assign unusedBytOff = req.bytoff;
    assign fillIdx      = missAddr[IDX_W-1:0];
    assign fillTag      = missAddr[ITAG_W+IDX_W-1:IDX_W];

    // Read side is always live; ihit qualifies the data
    assign imemload  = frames[req.idx].data;
    assign lookupHit = frames[req.idx].valid && (frames[req.idx].tag == req.tag);
    assign iaddr     = {missAddr, 2'b00};

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state and handshake decode
    always_comb begin
        nextState = state;
        ihit      = 1'b0;
        iREN      = 1'b0;
        missStart = 1'b0;
        fillDone  = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN & lookupHit;
                if (imemREN && !lookupHit) begin
                    missStart = 1'b1;
                    nextState = FILL;
                end
            end
            FILL: begin
                iREN = 1'b1;
                if (!iwait) begin
                    fillDone  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Miss address is frozen for the whole fill, so redirects cannot disturb it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)          missAddr <= '0;
        else if (missStart) missAddr <= imemaddr[31:2];
    end

    // Single write port, used only when a fill completes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            frames <= '{default: '0};
        end else if (fillDone) begin
            frames[fillIdx] <= '{valid: 1'b1, tag: fillTag, data: iload};
        end
    end

    // Statistics counters, wrapping naturally
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit)      hit_count  <= hit_count + 32'd1;
            if (missStart) miss_count <= miss_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (SETS = 16): directed vector table, hand
// sequences for multi-cycle corners, and a randomized run against a
// word-address reference model of the cache contents.
`timescale 1ns/1ps
module tb_icache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    int passCnt  = 0;
    int totalCnt = 0;

    // Memory: busy for memLat cycles of each request, then returns memWord(iaddr)
    int memLat  = 0;
    int busyCnt = 0;

    function automatic logic [31:0] memWord(logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C22_0004;
        return ((a ^ 32'hA5A5_0000) * 32'h0100_0193) + 32'd1;
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST)              busyCnt <= 0;
        else if (iREN && iwait) busyCnt <= busyCnt + 1;
        else                    busyCnt <= 0;
    end

    assign iwait = iREN && (busyCnt < memLat);
    always_comb iload = memWord(iaddr);

    // Reference model: which word address each frame holds, plus a pending fill
    bit          mValid [16];
    logic [31:0] mLine  [16];
    bit          mPend;
    logic [31:0] mFill;
    logic [31:0] mHits;
    logic [31:0] mMisses;

    function automatic bit mLookup(logic [31:0] a);
        int i;
        i = int'(a[5:2]);
        return mValid[i] && (mLine[i][31:6] == a[31:6]);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mLine[i]  = 32'd0;
        end
        mPend   = 1'b0;
        mFill   = 32'd0;
        mHits   = 32'd0;
        mMisses = 32'd0;
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // One clock: compare at the falling edge, advance the model, return after the rising edge
    task automatic step(output bit sawHit);
        bit          eHit, eRen, isHit;
        logic [31:0] eLoad;
        int          idx;
        @(negedge CLK);
        idx   = int'(imemaddr[5:2]);
        isHit = mLookup(imemaddr);
        eHit  = !mPend && imemREN && isHit;
        eRen  = mPend;
        eLoad = mValid[idx] ? memWord(mLine[idx]) : 32'd0;
        check("ihit",       32'(ihit),  32'(eHit));
        check("imemload",   imemload,   eLoad);
        check("iREN",       32'(iREN),  32'(eRen));
        check("iaddr",      iaddr,      mFill);
        check("hit_count",  hit_count,  mHits);
        check("miss_count", miss_count, mMisses);
        sawHit = ihit;
        if (eHit) mHits = mHits + 32'd1;
        if (!mPend) begin
            if (imemREN && !isHit) begin
                mPend   = 1'b1;
                mFill   = {imemaddr[31:2], 2'b00};
                mMisses = mMisses + 32'd1;
            end
        end else if (!iwait) begin
            mValid[int'(mFill[5:2])] = 1'b1;
            mLine[int'(mFill[5:2])]  = mFill;
            mPend = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic runUntilHit(output int cyc, output bit got);
        bit h;
        cyc = 0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(h);
            if (h) begin
                got = 1'b1;
                break;
            end
            cyc++;
        end
        if (!got) check("hit timeout", 32'd0, 32'd1);
    endtask

    // Called just after a rising edge; asserts reset asynchronously
    task automatic doReset();
        nRST = 1'b0;
        #2;
        modelClear();
        check("rst ihit",       32'(ihit), 32'd0);
        check("rst iREN",       32'(iREN), 32'd0);
        check("rst iaddr",      iaddr,     32'd0);
        check("rst imemload",   imemload,  32'd0);
        check("rst hit_count",  hit_count, 32'd0);
        check("rst miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          expCycles;
        logic [31:0] expData;
        logic [31:0] expMisses;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          cyc;
        bit          got, h;
        logic [31:0] h0;

        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        memLat   = 0;
        modelClear();

        // cold miss, warm hit, conflict eviction, re-miss, byte offset ignored
        tbl[0] = '{32'h0000_0040, 3, 5, 32'h8C22_0004,          32'd1};
        tbl[1] = '{32'h0000_0040, 0, 0, 32'h8C22_0004,          32'd1};
        tbl[2] = '{32'h0000_0080, 1, 3, memWord(32'h0000_0080), 32'd2};
        tbl[3] = '{32'h0000_0040, 2, 4, 32'h8C22_0004,          32'd3};
        tbl[4] = '{32'h0000_0047, 0, 2, memWord(32'h0000_0044), 32'd4};
        tbl[5] = '{32'h0000_0044, 0, 0, memWord(32'h0000_0044), 32'd4};

        @(posedge CLK);
        #1;
        doReset();

        for (int t = 0; t < 6; t++) begin
            imemREN  = 1'b1;
            imemaddr = tbl[t].addr;
            memLat   = tbl[t].lat;
            runUntilHit(cyc, got);
            check($sformatf("vec%0d cycles", t), 32'(cyc), 32'(tbl[t].expCycles));
            check($sformatf("vec%0d data", t),   imemload, tbl[t].expData);
            check($sformatf("vec%0d misses", t), miss_count, tbl[t].expMisses);
        end

        // Repeated hits during a stall count every cycle
        h0 = hit_count;
        repeat (4) step(h);
        check("stall hit_count", hit_count, h0 + 32'd4);
        check("stall iREN", 32'(iREN), 32'd0);

        // Datapath halts mid-fill: the fill still lands
        imemaddr = 32'h0000_0300;
        memLat   = 3;
        step(h);
        step(h);
        imemREN = 1'b0;
        repeat (5) step(h);
        check("halt iREN", 32'(iREN), 32'd0);
        imemREN = 1'b1;
        step(h);
        check("halt refill hit", 32'(h), 32'd1);
        check("halt refill data", imemload, memWord(32'h0000_0300));

        // Redirect mid-fill: fill address stays frozen
        imemaddr = 32'h0000_0100;
        memLat   = 4;
        step(h);
        step(h);
        imemaddr = 32'h0000_0204;
        for (int k = 0; k < 10; k++) begin
            if (!iREN) break;
            check("redirect iaddr", iaddr, 32'h0000_0100);
            step(h);
        end
        runUntilHit(cyc, got);
        check("redirect new fill cycles", 32'(cyc), 32'd6);
        check("redirect new fill iaddr", iaddr, 32'h0000_0204);
        imemaddr = 32'h0000_0100;
        step(h);
        check("redirect frame0 hit", 32'(h), 32'd1);
        check("redirect frame0 data", imemload, memWord(32'h0000_0100));

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            imemREN = ($urandom_range(0, 9) < 8);
            if (!iREN) memLat = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0)
                imemaddr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            step(h);
        end

        // Drain any fill, then reset in the middle of a new one
        imemREN = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!mPend) break;
            step(h);
        end
        imemREN  = 1'b1;
        imemaddr = 32'h0000_03C0;
        memLat   = 5;
        step(h);
        step(h);
        check("midfill iREN", 32'(iREN), 32'd1);
        doReset();
        runUntilHit(cyc, got);
        check("post-reset refill cycles", 32'(cyc), 32'd7);
        check("post-reset miss_count", miss_count, 32'd1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache that answers the datapath's instruction fetch requests and fills misses from the memory controller. It sits between the datapath (fetch port `imemREN`/`imemaddr` -> `ihit`/`imemload`) and the memory controller instruction port (`iREN`/`iaddr` <- `iwait`/`iload`). It uses a blocking, single-outstanding-fill state machine and keeps hit and miss statistics counters.

## Interface
- `SETS`, default 16: number of frames; power of two; index width `IDX_W = log2(SETS)`.
- `CLK` in 1: clock; all state changes on the rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `imemREN` in 1: datapath fetch request.
- `imemaddr` in 32: fetch byte address; bits [1:0] ignored.
- `ihit` out 1: `imemload` is valid this cycle.
- `imemload` out 32: instruction word.
- `iREN` out 1: fill read request to the memory controller.
- `iaddr` out 32: fill word address, with [1:0] = 00.
- `iwait` in 1: memory busy; a fill completes on the first cycle with `iREN` high and `iwait` low.
- `iload` in 32: fill data, valid when `iwait` is low.
- `hit_count` out 32: number of cycles with `ihit` high; wraps on overflow.
- `miss_count` out 32: number of misses issued; wraps on overflow.

## Operation
- Address split: tag = `imemaddr[31:IDX_W+2]`, index = `imemaddr[IDX_W+1:2]`. Each frame holds valid, tag and 32-bit data.
- `imemload` always shows the data of the frame at the current index. The consumer qualifies it with `ihit`.
- **IDLE** state:
  - `ihit = imemREN & valid[idx] & (tag == frame tag)`.
  - `iREN` = 0.
  - On `imemREN` with a miss: latch `{tag,idx}` into `miss_addr`, increment `miss_count`, go to FILL.
- **FILL** state:
  - `iREN` = 1, `iaddr = {miss_addr,2'b00}`, `ihit` = 0.
  - When `iwait` is low: write `iload`, the latched tag, and valid=1 into frame `miss_addr.idx`, then go to IDLE.
- The fill address is frozen for the whole fill. If `imemaddr` changes during FILL (for example a branch redirect), the fill still completes to the latched address. The new address is then looked up in IDLE on the next cycle and may miss again.
- If `imemREN` drops during FILL (datapath halting), the fill still completes. `ihit` stays 0.
- A fill overwrites any existing frame at that index; there is no write-back, because instruction frames are never dirty.
- There is no forwarding of `iload` to `imemload`. A miss is served from the array one cycle after the fill.

## Timing
- Hit latency: 0 cycles; `ihit` is combinational from `imemaddr` in IDLE.
- Miss: detected in cycle 0, FILL from cycle 1. If memory drops `iwait` in cycle 1+L, the frame is written at the end of that cycle and `ihit` = 1 in cycle 2+L. Miss penalty is L+2 cycles.
- Reset (asynchronous, any time, including mid-fill):
  - State returns to IDLE; all valid bits, tags and data are cleared; `miss_addr` = 0; both counters = 0.
  - Outputs then read `ihit`=0, `iREN`=0, `iaddr`=0, `imemload`=0.
  - An aborted fill writes nothing.
- `hit_count` increments in every cycle with `ihit` high, including repeated hits on the same address during datapath stalls.
- `miss_count` increments in the IDLE->FILL cycle only.
- Both counters wrap from 0xFFFFFFFF to 0.
- The single frame write port is used only in FILL. A read and a fill to the same frame in one cycle is impossible, because `ihit` is 0 in FILL.

## Structure
- In `cpu_types_pkg`:
  - a packed `icachef_t {tag, idx, bytoff}` address breakdown;
  - an `icache_frame_t {valid, tag, data}` struct;
  - an enum `icache_state_t {IDLE, FILL}`.
- `IDX_W` and `ITAG_W` are derived from `SETS` as localparams.
- No sub-module: the frame array, FSM and counters are inline. The port lists map one-to-one onto the cache side of the datapath-cache interface and the instruction side of the cache-memory interface.

## Test plan
- **Cold miss:** reset, `imemREN`=1, `imemaddr`=0x00000040, memory with `iwait` high for 3 cycles then `iload`=0x8C220004. Expect `iREN`=1 and `iaddr`=0x40 for 4 cycles, then `ihit`=1 with `imemload`=0x8C220004. `miss_count`=1.
- **Warm hit:** same address re-requested later. Expect `ihit`=1 in the same cycle, `iREN`=0, and `hit_count` incrementing once per cycle.
- **Conflict:** with `SETS`=16, fill 0x00000040, then request 0x00000080 (same index 0, different tag). Expect a miss and a fill. A re-request of 0x40 then misses again; `miss_count`=3.
- **Redirect mid-fill:** miss on 0x100; during FILL change `imemaddr` to 0x204. Expect `iaddr` held at 0x100 until `iwait` drops, then a new fill for 0x204. Frame 0 holds 0x100's data.
- **Reset mid-fill:** assert `nRST`=0 during FILL. Expect `iREN`=0 immediately. After release, a request to the same address misses (valid cleared) and both counters read 0.
